// File: rtl/message_scroller_if.sv
// Control/write/display bundle between a message source and message_scroller.
// The master drives the control and write signals; the slave (the scroller)
// drives the window of symbol codes and its status flags.
interface message_scroller_if #(
    parameter int DEPTH  = 16,
    parameter int DIGITS = 6
);
    logic                         clear;
    logic                         wr_en;
    logic [4:0]                   wr_data;
    logic                         run;
    logic [5*DIGITS-1:0]          symbols;
    logic [$clog2(DEPTH+1)-1:0]   len;
    logic                         full;
    logic                         running;
    logic                         wrap;

    modport master (
        output clear, wr_en, wr_data, run,
        input  symbols, len, full, running, wrap
    );

    modport slave (
        input  clear, wr_en, wr_data, run,
        output symbols, len, full, running, wrap
    );
endinterface

// File: rtl/message_scroller.sv
// Message buffer plus scrolling window for the HEX display stages.
// A message of 5-bit codes is appended while idle and shown statically;
// while running, the window slides right-to-left over the message followed
// by DIGITS blanks, advancing one position every STEP_CYCLES clocks.
module message_scroller #(
    parameter int         DEPTH       = 16,
    parameter int         DIGITS      = 6,
    parameter int         STEP_CYCLES = 25_000_000,
    parameter logic [4:0] BLANK       = 5'd31
) (
    input  logic              clk,
    input  logic              reset,
    message_scroller_if.slave bus
);
    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam int OFF_W = $clog2(DEPTH + DIGITS);
    localparam int SUM_W = $clog2(2 * (DEPTH + DIGITS));
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [4:0]         buffer [DEPTH];
    logic [LEN_W-1:0]   len;
    logic [OFF_W-1:0]   offset;
    logic [CNT_W-1:0]   cnt;
    logic               running;
    logic               wrap;

    logic               full;
    logic               write_accept;
    logic [OFF_W-1:0]   period_m1;
    logic [SUM_W-1:0]   period;
    logic [5*DIGITS-1:0] symbols_c;

    // Length of the virtual sequence (message + trailing blanks) and its last index.
    assign full      = (len == LEN_W'(DEPTH));
    assign period    = SUM_W'(len) + SUM_W'(DIGITS);
    assign period_m1 = OFF_W'(len) + OFF_W'(DIGITS - 1);

    // Appends happen only while idle, with room left, and never on a clearing cycle.
    assign write_accept = !reset && !bus.clear && (state == IDLE) && bus.wr_en && !full;

    // Message storage; only entries below len are ever displayed.
    // NOTE: the buffer has no reset on purpose -- len gates every read, so stale
    // contents are invisible and the array can map onto plain RAM/LUT storage.
    always_ff @(posedge clk) begin
        if (write_accept)
            buffer[len[IDX_W-1:0]] <= bus.wr_data;
    end

    // Control state: length, scroll offset, step counter and registered flags.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            state   <= IDLE;
            len     <= '0;
            offset  <= '0;
            cnt     <= '0;
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_accept)
                        len <= len + LEN_W'(1);
                    // Entry decision uses the length before any same-cycle append.
                    if (bus.run && (len != '0)) begin
                        state   <= RUN;
                        running <= 1'b1;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    if (!bus.run) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        offset  <= '0;
                        cnt     <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (offset == period_m1) begin
                            offset <= '0;
                            wrap   <= 1'b1;
                        end else begin
                            offset <= offset + OFF_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Window decode: digit i shows sequence position (offset + i) mod period.
    // NOTE: combinational logic uses blocking assignments with a default first,
    // so pos is a pure temporary and no latch can be inferred.
    always_comb begin
        logic [SUM_W-1:0] pos;
        pos       = '0;
        symbols_c = '0;
        for (int i = 0; i < DIGITS; i++) begin
            // offset < period and i < DIGITS <= period, so one subtraction wraps it.
            pos = SUM_W'(offset) + SUM_W'(i);
            if (pos >= period)
                pos = pos - period;
            if (pos < SUM_W'(len))
                symbols_c[5*(DIGITS-i)-1 -: 5] = buffer[pos[IDX_W-1:0]];
            else
                symbols_c[5*(DIGITS-i)-1 -: 5] = BLANK;
        end
    end

    assign bus.symbols = symbols_c;
    assign bus.len     = len;
    assign bus.full    = full;
    assign bus.running = running;
    assign bus.wrap    = wrap;

endmodule

// File: tb/tb_message_scroller.sv
// Self-checking bench for message_scroller: directed scenarios followed by
// randomized control/write traffic, all compared against a queue-based model
// that derives the window position from elapsed cycles in RUN.
module tb_message_scroller;
    localparam int DEPTH  = 16;
    localparam int DIGITS = 6;
    localparam int STEP   = 4;
    localparam logic [4:0] BLANK = 5'd31;

    logic clk;
    logic reset;

    message_scroller_if #(.DEPTH(DEPTH), .DIGITS(DIGITS)) bus ();

    message_scroller #(
        .DEPTH      (DEPTH),
        .DIGITS     (DIGITS),
        .STEP_CYCLES(STEP),
        .BLANK      (BLANK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: message as a queue, RUN flag, edges elapsed since RUN entry.
    int m_msg[$];
    bit m_run  = 1'b0;
    int m_n    = 0;
    bit m_wrap = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5*DIGITS-1:0] sym6(input int a, b, c, d, e, f);
        return {5'(a), 5'(b), 5'(c), 5'(d), 5'(e), 5'(f)};
    endfunction

    function automatic logic [5*DIGITS-1:0] model_symbols();
        logic [5*DIGITS-1:0] s;
        int p;
        int off;
        int idx;
        s   = '0;
        p   = m_msg.size() + DIGITS;
        off = m_run ? (m_n / STEP) % p : 0;
        for (int i = 0; i < DIGITS; i++) begin
            idx = (off + i) % p;
            s[5*(DIGITS-i)-1 -: 5] = (idx < m_msg.size()) ? 5'(m_msg[idx]) : BLANK;
        end
        return s;
    endfunction

    // Advance the model by one clock edge using the inputs presented to the DUT.
    task automatic model_edge();
        int pre;
        m_wrap = 1'b0;
        if (reset || bus.clear) begin
            m_msg.delete();
            m_run = 1'b0;
            m_n   = 0;
        end else if (!m_run) begin
            pre = m_msg.size();
            if (bus.wr_en && pre < DEPTH)
                m_msg.push_back(int'(bus.wr_data));
            if (bus.run && pre != 0) begin
                m_run = 1'b1;
                m_n   = 0;
            end
        end else if (!bus.run) begin
            m_run = 1'b0;
            m_n   = 0;
        end else begin
            m_n++;
            if (m_n % (STEP * (m_msg.size() + DIGITS)) == 0)
                m_wrap = 1'b1;
        end
    endtask

    task automatic check_all();
        check("symbols", 64'(bus.symbols), 64'(model_symbols()));
        check("len",     64'(bus.len),     64'(m_msg.size()));
        check("full",    64'(bus.full),    64'(m_msg.size() == DEPTH));
        check("running", 64'(bus.running), 64'(m_run));
        check("wrap",    64'(bus.wrap),    64'(m_wrap));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic write(input int code);
        bus.wr_en   = 1'b1;
        bus.wr_data = 5'(code);
        cycle();
        bus.wr_en   = 1'b0;
    endtask

    int wraps;

    initial begin
        reset       = 1'b1;
        bus.clear   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.run     = 1'b0;
        cycle();
        cycle();
        check("rst_symbols", 64'(bus.symbols), 64'(sym6(31, 31, 31, 31, 31, 31)));
        check("rst_len", 64'(bus.len), 64'd0);
        reset = 1'b0;
        cycle();

        // Static message 1,2,3.
        write(1);
        write(2);
        write(3);
        check("len3", 64'(bus.len), 64'd3);
        check("static123", 64'(bus.symbols), 64'(sym6(1, 2, 3, 31, 31, 31)));

        // Scroll: one step after STEP edges, wrap after P*STEP = 36 edges.
        bus.run = 1'b1;
        cycle();
        check("running_up", 64'(bus.running), 64'd1);
        wraps = 0;
        for (int k = 1; k <= 36; k++) begin
            cycle();
            if (bus.wrap) wraps++;
            if (k == 4)
                check("step1", 64'(bus.symbols), 64'(sym6(2, 3, 31, 31, 31, 31)));
        end
        check("wrap_count", 64'(wraps), 64'd1);
        check("wrap_window", 64'(bus.symbols), 64'(sym6(1, 2, 3, 31, 31, 31)));
        repeat (9) cycle();
        bus.run = 1'b0;
        cycle();
        check("stop_window", 64'(bus.symbols), 64'(sym6(1, 2, 3, 31, 31, 31)));
        check("stop_running", 64'(bus.running), 64'd0);

        // Fill to DEPTH, then one extra write that must be dropped.
        bus.clear = 1'b1;
        cycle();
        bus.clear = 1'b0;
        for (int k = 0; k < DEPTH + 1; k++) write(7);
        check("full_len", 64'(bus.len), 64'd16);
        check("full_flag", 64'(bus.full), 64'd1);

        // Writes during RUN are ignored; clear beats a simultaneous write.
        bus.run = 1'b1;
        repeat (6) cycle();
        bus.clear = 1'b0;
        write(9);
        check("run_write_len", 64'(bus.len), 64'd16);
        repeat (3) cycle();
        bus.clear   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 5'd5;
        cycle();
        bus.clear = 1'b0;
        bus.wr_en = 1'b0;
        check("clr_len", 64'(bus.len), 64'd0);
        check("clr_symbols", 64'(bus.symbols), 64'(sym6(31, 31, 31, 31, 31, 31)));

        // run with an empty message stays idle and never wraps.
        wraps = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (bus.wrap || bus.running) wraps++;
        end
        check("empty_run", 64'(wraps), 64'd0);
        bus.run = 1'b0;
        cycle();

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            reset       = ($urandom_range(0, 499) == 0);
            bus.clear   = ($urandom_range(0, 79) == 0);
            bus.wr_en   = ($urandom_range(0, 2) == 0);
            bus.wr_data = 5'($urandom);
            if ($urandom_range(0, 39) == 0) bus.run = ~bus.run;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
